pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable inputs of the PC and the IF/ID, ID/EX, EX/ME and ME/WB stage registers.
- Inserts load-use bubbles and flushes wrong-path instructions on taken branches.
- Runs the request/acknowledge handshake with a variable-latency data memory, freezing the whole pipeline until the access completes.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes
// and a req/ack handshake with a variable-latency data memory that freezes every stage.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [4:0]       rw_ex,
    input  logic             wreg_ex,
    input  logic             rmem_ex,
    input  logic             rmem_me,
    input  logic             wmem_me,
    input  logic             taken_ex,
    input  logic             dmem_ack,
    input  logic             stat_clr,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exme,
    output logic             en_mewb,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             busy
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun,
        StWait,
        StErr
    } state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;

    logic memop;
    logic rs_hit;
    logic rt_hit;
    logic lu;

    assign memop  = rmem_me | wmem_me;
    assign rs_hit = use_rs_id && (rs_id == rw_ex);
    assign rt_hit = use_rt_id && (rt_id == rw_ex);
    assign lu     = rmem_ex && wreg_ex && (rw_ex != 5'd0) && (rs_hit || rt_hit);

    // Enables for a cycle in which the pipeline advances; a taken branch overrides lu.
    logic adv_front;
    logic adv_bubble;

    assign adv_front  = taken_ex || !lu;
    assign adv_bubble = taken_ex || lu;

    always_comb begin
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exme     = 1'b0;
        en_mewb     = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        dmem_req    = 1'b0;
        mem_err     = 1'b0;
        busy        = 1'b0;
        if (reset_0) begin
            unique case (state_q)
                StRun: begin
                    dmem_req = memop;
                    if (!(memop && !dmem_ack)) begin
                        en_pc       = adv_front;
                        en_ifid     = adv_front;
                        en_idex     = 1'b1;
                        en_exme     = 1'b1;
                        en_mewb     = 1'b1;
                        flush_ifid  = taken_ex;
                        bubble_idex = adv_bubble;
                    end
                end
                StWait: begin
                    dmem_req = 1'b1;
                    busy     = 1'b1;
                    if (dmem_ack) begin
                        en_pc       = adv_front;
                        en_ifid     = adv_front;
                        en_idex     = 1'b1;
                        en_exme     = 1'b1;
                        en_mewb     = 1'b1;
                        flush_ifid  = taken_ex;
                        bubble_idex = adv_bubble;
                    end
                end
                StErr: begin
                    mem_err = 1'b1;
                end
                default: begin
                    mem_err = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (memop && !dmem_ack) begin
                        state_q <= StWait;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                StWait: begin
                    // A late ack on the timeout cycle still completes the access.
                    if (dmem_ack) begin
                        state_q <= StRun;
                        wait_q  <= '0;
                    end else if (wait_q >= WAIT_LIMIT) begin
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StRun;
                    wait_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            cnt_q <= '0;
        end else if (stat_clr) begin
            cnt_q <= '0;
        end else if (!en_pc && (state_q != StErr) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl with a short timeout and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;

    // {en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid, bubble_idex, dmem_req, mem_err, busy}
    localparam logic [9:0] ZERO  = 10'b00000_00_0_0_0;
    localparam logic [9:0] RUNV  = 10'b11111_00_0_0_0;
    localparam logic [9:0] RUNM  = 10'b11111_00_1_0_0;
    localparam logic [9:0] LUV   = 10'b00111_01_0_0_0;
    localparam logic [9:0] BRV   = 10'b11111_11_0_0_0;
    localparam logic [9:0] MSTL  = 10'b00000_00_1_0_0;
    localparam logic [9:0] WAITV = 10'b00000_00_1_0_1;
    localparam logic [9:0] ACKV  = 10'b11111_00_1_0_1;
    localparam logic [9:0] ACKBR = 10'b11111_11_1_0_1;
    localparam logic [9:0] ACKLU = 10'b00111_01_1_0_1;
    localparam logic [9:0] ERRV  = 10'b00000_00_0_1_0;

    logic          clock = 1'b0;
    logic          reset_0;
    logic [4:0]    rs_id, rt_id, rw_ex;
    logic          use_rs_id, use_rt_id, wreg_ex, rmem_ex, rmem_me, wmem_me;
    logic          taken_ex, dmem_ack, stat_clr;
    logic          en_pc, en_ifid, en_idex, en_exme, en_mewb;
    logic          flush_ifid, bubble_idex, dmem_req, mem_err, busy;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string       tag;
        logic [9:0]  outs;
        int unsigned cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .use_rs_id  (use_rs_id),
        .use_rt_id  (use_rt_id),
        .rw_ex      (rw_ex),
        .wreg_ex    (wreg_ex),
        .rmem_ex    (rmem_ex),
        .rmem_me    (rmem_me),
        .wmem_me    (wmem_me),
        .taken_ex   (taken_ex),
        .dmem_ack   (dmem_ack),
        .stat_clr   (stat_clr),
        .en_pc      (en_pc),
        .en_ifid    (en_ifid),
        .en_idex    (en_idex),
        .en_exme    (en_exme),
        .en_mewb    (en_mewb),
        .flush_ifid (flush_ifid),
        .bubble_idex(bubble_idex),
        .dmem_req   (dmem_req),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the inputs just driven, then compare at the falling edge.
    task automatic step(input string tag, input logic [9:0] eo, input int unsigned ec);
        exp_t e;
        exp_q.push_back('{tag: tag, outs: eo, cnt: ec});
        @(negedge clock);
        e = exp_q.pop_front();
        check_eq({e.tag, "_out"}, 32'({en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid,
                                       bubble_idex, dmem_req, mem_err, busy}), 32'(e.outs));
        check_eq({e.tag, "_cnt"}, 32'(stall_cnt), e.cnt);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rs_id = 5'd1; rt_id = 5'd2; rw_ex = 5'd3;
        use_rs_id = 1'b1; use_rt_id = 1'b1; wreg_ex = 1'b1; rmem_ex = 1'b0;
        rmem_me = 1'b0; wmem_me = 1'b0; taken_ex = 1'b0; dmem_ack = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic set_lu();
        rmem_ex = 1'b1; wreg_ex = 1'b1; rw_ex = 5'd5; rs_id = 5'd5; use_rs_id = 1'b1;
    endtask

    initial begin
        idle();
        reset_0 = 1'b0;
        taken_ex = 1'b1;
        rmem_me = 1'b1;
        step("rst_hold", ZERO, 0);
        idle();
        reset_0 = 1'b1;

        for (int i = 0; i < 3; i++) step("alu", RUNV, 0);

        set_lu();
        step("lu_rs", LUV, 0);
        idle();
        step("lu_after", RUNV, 1);
        set_lu();
        rw_ex = 5'd0; rs_id = 5'd0;
        step("lu_r0", RUNV, 1);
        idle();
        rmem_ex = 1'b1; rw_ex = 5'd7; rt_id = 5'd7;
        step("lu_rt", LUV, 1);
        use_rt_id = 1'b0;
        step("lu_nouse", RUNV, 2);
        idle();

        wmem_me = 1'b1;
        step("st_req", MSTL, 2);
        step("st_w1", WAITV, 3);
        step("st_w2", WAITV, 4);
        dmem_ack = 1'b1;
        step("st_ack", ACKV, 5);
        idle();
        step("st_done", RUNV, 5);

        rmem_me = 1'b1; dmem_ack = 1'b1;
        step("ld_zw", RUNM, 5);
        idle();

        set_lu();
        taken_ex = 1'b1;
        step("br_lu", BRV, 5);
        idle();
        step("br_after", RUNV, 5);

        wmem_me = 1'b1; taken_ex = 1'b1;
        step("brw_req", MSTL, 5);
        step("brw_w1", WAITV, 6);
        dmem_ack = 1'b1;
        step("brw_ack", ACKBR, 7);
        idle();
        step("brw_done", RUNV, 7);

        rmem_me = 1'b1;
        set_lu();
        step("luw_req", MSTL, 7);
        dmem_ack = 1'b1;
        step("luw_ack", ACKLU, 8);
        idle();
        step("luw_done", RUNV, 9);

        rmem_me = 1'b1;
        step("late_req", MSTL, 9);
        step("late_w1", WAITV, 10);
        step("late_w2", WAITV, 11);
        step("late_w3", WAITV, 12);
        dmem_ack = 1'b1;
        step("late_ack", ACKV, 13);
        idle();
        step("late_done", RUNV, 13);

        stat_clr = 1'b1;
        step("clr", RUNV, 13);
        stat_clr = 1'b0;
        step("clr_done", RUNV, 0);

        rmem_me = 1'b1;
        step("to_req", MSTL, 0);
        step("to_w1", WAITV, 1);
        step("to_w2", WAITV, 2);
        step("to_w3", WAITV, 3);
        step("to_w4", WAITV, 4);
        step("to_err", ERRV, 5);
        dmem_ack = 1'b1;
        step("err_ack", ERRV, 5);
        step("err_hold", ERRV, 5);
        reset_0 = 1'b0;
        step("err_rst", ZERO, 0);
        idle();
        reset_0 = 1'b1;
        step("err_rel", RUNV, 0);

        set_lu();
        for (int i = 0; i < 18; i++) step("sat", LUV, (i > 15) ? 15 : i);
        stat_clr = 1'b1;
        step("sat_clr", LUV, 15);
        stat_clr = 1'b0;
        step("sat_zero", LUV, 0);
        step("sat_inc", LUV, 1);
        idle();

        wmem_me = 1'b1;
        step("rw_req", MSTL, 2);
        step("rw_w1", WAITV, 3);
        reset_0 = 1'b0;
        step("rw_rst", ZERO, 0);
        idle();
        reset_0 = 1'b1;
        step("rw_rel", RUNV, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
